// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master with all four CPOL/CPHA modes,
// a runtime clock divider, NUM_CS active-low chip selects and an optional
// chip-select hold between words so bursts can share one CS assertion.
// Timing is built from half-periods of H = clk_div+1 system clocks: one
// half-period of CS setup, 2*DATA_WIDTH half-periods of SCK activity and one
// half-period of CS tail before the received word is presented.
// The CS-release request input is named release_cs because "release" is a
// reserved word in SystemVerilog.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  hold_cs,
  input  logic                  release_cs,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sck,
  output logic [NUM_CS-1:0]     cs_n,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  new_data
);

  // Half-period index inside TRANSFER runs 0 .. 2*DATA_WIDTH-1.
  localparam int HALF_W = $clog2(2 * DATA_WIDTH);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_WIDTH - 1);
  localparam logic [HALF_W-1:0] PEN_HALF  = HALF_W'(2 * DATA_WIDTH - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TRANSFER,
    ST_FINISH,
    ST_HOLD
  } state_t;

  state_t state_reg, state_next;

  // Configuration captured on the accepting cycle.
  logic                  cpol_reg;
  logic                  cpha_reg;
  logic [DIV_WIDTH-1:0]  div_reg;
  logic [CS_W-1:0]       cs_sel_reg;
  logic                  hold_reg;

  // Timing.
  logic [DIV_WIDTH-1:0]  cnt_reg;
  logic [HALF_W-1:0]     half_reg;

  // Datapath.
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic                  mosi_reg;
  logic                  sck_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  new_data_reg;

  // Decoded per-cycle events.
  logic phase_end;
  logic accept;
  logic toggle;
  logic leading;
  logic last_toggle;
  logic finish_done;
  logic sample_en;
  logic shift_en;
  logic cs_active;

  assign phase_end = (cnt_reg == div_reg);
  assign busy      = (state_reg == ST_SETUP) || (state_reg == ST_TRANSFER) ||
                     (state_reg == ST_FINISH);
  assign cs_active = (state_reg != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle strobes; an SCK toggle happens on the
  // first cycle of each half-period, the final half-period has none after it.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    toggle      = 1'b0;
    leading     = 1'b0;
    last_toggle = 1'b0;
    finish_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_next = ST_TRANSFER;
          toggle     = 1'b1;
          leading    = 1'b1;
        end
      end
      ST_TRANSFER: begin
        if (phase_end) begin
          if (half_reg == LAST_HALF) begin
            state_next = ST_FINISH;
          end else begin
            // Entering half-period half_reg+1: odd index means leading edge.
            toggle      = 1'b1;
            leading     = half_reg[0];
            last_toggle = (half_reg == PEN_HALF);
          end
        end
      end
      ST_FINISH: begin
        if (phase_end) begin
          finish_done = 1'b1;
          state_next  = hold_reg ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
        end else if (release_cs) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sampling edge is the leading one for cpha=0, trailing for cpha=1; the
  // driving edge is the other one, except that cpha=0 preloads the MSB and
  // therefore skips the final trailing edge so mosi rests on the LSB.
  assign sample_en = toggle & (leading ^ cpha_reg);
  assign shift_en  = toggle & (cpha_reg ? leading : (~leading & ~last_toggle));

  // Capture the transfer configuration when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol_reg   <= 1'b0;
      cpha_reg   <= 1'b0;
      div_reg    <= '0;
      cs_sel_reg <= '0;
      hold_reg   <= 1'b0;
    end else if (accept) begin
      cpol_reg   <= cpol;
      cpha_reg   <= cpha;
      div_reg    <= clk_div;
      cs_sel_reg <= cs_sel;
      hold_reg   <= hold_cs;
    end
  end

  // Cycle counter within a half-period and half-period index within TRANSFER.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      half_reg <= '0;
    end else begin
      if (busy && !phase_end) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
      if (state_reg == ST_SETUP) begin
        half_reg <= '0;
      end else if (state_reg == ST_TRANSFER && phase_end) begin
        half_reg <= half_reg + 1'b1;
      end
    end
  end

  // SCK: forced to the new idle level on accept, then toggled on each
  // half-period boundary; 2*DATA_WIDTH toggles bring it back to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_reg <= 1'b0;
    end else if (accept) begin
      sck_reg <= cpol;
    end else if (toggle) begin
      sck_reg <= ~sck_reg;
    end
  end

  // Transmit shifter: cpha=0 presents the MSB from the first SETUP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_reg   <= '0;
      mosi_reg <= 1'b0;
    end else if (accept) begin
      if (cpha) begin
        tx_reg <= data_in;
      end else begin
        tx_reg   <= {data_in[DATA_WIDTH-2:0], 1'b0};
        mosi_reg <= data_in[DATA_WIDTH-1];
      end
    end else if (shift_en) begin
      mosi_reg <= tx_reg[DATA_WIDTH-1];
      tx_reg   <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Receive shifter; the word is published only when FINISH completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_reg       <= '0;
      data_out_reg <= '0;
      new_data_reg <= 1'b0;
    end else begin
      new_data_reg <= finish_done;
      if (sample_en) begin
        rx_reg <= {rx_reg[DATA_WIDTH-2:0], miso};
      end
      if (finish_done) begin
        data_out_reg <= rx_reg;
      end
    end
  end

  // Chip-select decode; an out-of-range index asserts no line.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign cs_n[gi] = ~(cs_active && (cs_sel_reg == CS_W'(gi)));
    end
  endgenerate

  assign mosi     = mosi_reg;
  assign sck      = sck_reg;
  assign data_out = data_out_reg;
  assign new_data = new_data_reg;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed and randomized transfers against a
// behavioural SPI slave. Each accepted start pushes its expected outcome
// into a queue; a monitor acting as the slave drives miso, records mosi on
// the slave's sampling edges and checks each word when new_data pulses.
module tb_spi_master_multi;

  localparam int W   = 8;
  localparam int NCS = 4;
  localparam int DW  = 8;
  localparam int CSW = 2;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   data_in;
  logic           cpol;
  logic           cpha;
  logic [DW-1:0]  clk_div;
  logic [CSW-1:0] cs_sel;
  logic           hold_cs;
  logic           release_cs;
  logic           miso;
  logic           mosi;
  logic           sck;
  logic [NCS-1:0] cs_n;
  logic [W-1:0]   data_out;
  logic           busy;
  logic           new_data;

  spi_master_multi #(
    .DATA_WIDTH(W),
    .NUM_CS    (NCS),
    .DIV_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .cpol      (cpol),
    .cpha      (cpha),
    .clk_div   (clk_div),
    .cs_sel    (cs_sel),
    .hold_cs   (hold_cs),
    .release_cs(release_cs),
    .miso      (miso),
    .mosi      (mosi),
    .sck       (sck),
    .cs_n      (cs_n),
    .data_out  (data_out),
    .busy      (busy),
    .new_data  (new_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
    logic         cpol;
    logic         cpha;
    logic         hold;
    int           h;
    int           cs;
  } xfer_t;

  xfer_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Chip-select pattern a slave expects for a given index.
  function automatic logic [NCS-1:0] cs_pat(input int idx);
    logic [NCS-1:0] p;
    p = '1;
    if (idx < NCS) p[idx] = 1'b0;
    return p;
  endfunction

  // Monitor + slave model, evaluated on the falling edge.
  initial begin
    xfer_t        cur;
    xfer_t        e;
    logic         active;
    int           busy_cnt;
    int           toggles;
    int           bit_idx;
    logic [W-1:0] mosi_word;
    logic         cs_bad;
    logic         busy_prev;
    logic         sck_prev;
    logic         nd_prev;
    active    = 1'b0;
    busy_cnt  = 0;
    toggles   = 0;
    bit_idx   = 0;
    mosi_word = '0;
    cs_bad    = 1'b0;
    busy_prev = 1'b0;
    sck_prev  = 1'b0;
    nd_prev   = 1'b0;
    miso      = 1'b0;
    forever begin
      @(negedge clk);
      if (nd_prev) check("new_data_width", 32'(new_data), 32'd0);
      if (new_data === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_new_data");
        end else begin
          e = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(e.rx));
          check("mosi_word", 32'(mosi_word), 32'(e.tx));
          check("busy_cycles", 32'(busy_cnt), 32'(e.h * (2 * W + 2)));
          check("sck_toggles", 32'(toggles), 32'(2 * W));
          check("cs_n_during", 32'(cs_bad), 32'd0);
          check("cs_n_after", 32'(cs_n), 32'(e.hold ? cs_pat(e.cs) : {NCS{1'b1}}));
          check("busy_at_new_data", 32'(busy), 32'd0);
          check("sck_idle_end", 32'(sck), 32'(e.cpol));
          $display("xfer tx=%02h rx=%02h mode=%0d%0d H=%0d cs=%0d hold=%0d -> data_out=%02h",
                   e.tx, e.rx, e.cpol, e.cpha, e.h, e.cs, e.hold, data_out);
        end
      end
      if (busy === 1'b1 && !busy_prev) begin
        if (exp_q.size() > 0) begin
          cur    = exp_q[0];
          active = 1'b1;
          check("sck_idle_setup", 32'(sck), 32'(cur.cpol));
          if (!cur.cpha) begin
            miso    = cur.rx[W-1];
            bit_idx = W - 2;
          end else begin
            bit_idx = W - 1;
          end
        end else begin
          active = 1'b0;
          fail("unexpected_busy");
        end
        busy_cnt  = 1;
        toggles   = 0;
        mosi_word = '0;
        cs_bad    = 1'b0;
      end else if (busy === 1'b1 && active) begin
        busy_cnt++;
        if (sck !== sck_prev) begin
          toggles++;
          if (sck == (cur.cpol ^ ~cur.cpha)) begin
            mosi_word = {mosi_word[W-2:0], mosi};
          end else if (bit_idx >= 0) begin
            miso = cur.rx[bit_idx];
            bit_idx--;
          end
        end
      end
      if (busy === 1'b1 && active && cs_n !== cs_pat(cur.cs)) cs_bad = 1'b1;
      busy_prev = (busy === 1'b1);
      sck_prev  = sck;
      nd_prev   = (new_data === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) fail("wait_idle_timeout");
  endtask

  // Issue one accepted start and record its expected outcome.
  task automatic issue(input logic [W-1:0] tx, input logic [W-1:0] rx, input logic cp,
                       input logic ch, input int div, input int cs, input logic hold);
    xfer_t x;
    wait_idle();
    data_in = tx;
    cpol    = cp;
    cpha    = ch;
    clk_div = DW'(div);
    cs_sel  = CSW'(cs);
    hold_cs = hold;
    start   = 1'b1;
    x.tx = tx; x.rx = rx; x.cpol = cp; x.cpha = ch; x.hold = hold;
    x.h  = div + 1; x.cs = cs;
    exp_q.push_back(x);
    tick();
    start   = 1'b0;
    data_in = W'($urandom);
    cpol    = 1'($urandom);
    cpha    = 1'($urandom);
    clk_div = DW'($urandom);
    cs_sel  = CSW'($urandom);
    hold_cs = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; data_in = '0; cpol = 1'b0; cpha = 1'b0;
    clk_div = '0; cs_sel = '0; hold_cs = 1'b0; release_cs = 1'b0;
    repeat (3) tick();
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'hF);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_new_data", 32'(new_data), 32'd0);
    rst = 1'b1;
    tick();

    // Mode 0, H=2.
    issue(8'hA5, 8'hA5, 1'b0, 1'b0, 1, 0, 1'b0);
    // Mode 3, H=1.
    issue(8'h81, 8'h3C, 1'b1, 1'b1, 0, 1, 1'b0);
    // Burst on CS 2.
    issue(8'h11, 8'hE7, 1'b0, 1'b0, 1, 2, 1'b1);
    wait_idle();
    check("burst_hold_cs2", 32'(cs_n), 32'h B);
    issue(8'h22, 8'h4D, 1'b0, 1'b0, 1, 2, 1'b0);
    // Hold on CS 3, then release.
    issue(8'hF0, 8'h0F, 1'b0, 1'b1, 0, 3, 1'b1);
    wait_idle();
    check("hold_cs3", 32'(cs_n), 32'h7);
    release_cs = 1'b1;
    tick();
    release_cs = 1'b0;
    check("release_cs_n", 32'(cs_n), 32'hF);
    for (int i = 0; i < 3; i++) begin
      check("release_busy", 32'(busy), 32'd0);
      check("release_new_data", 32'(new_data), 32'd0);
      tick();
    end
    // Start while busy is ignored.
    issue(8'h5A, 8'hC3, 1'b0, 1'b1, 2, 1, 1'b0);
    repeat (10) tick();
    start = 1'b1; data_in = 8'hFF;
    tick();
    start = 1'b0;
    check("busy_ignore", 32'(busy), 32'd1);
    check("data_out_hold", 32'(data_out), 32'h0F);
    // Reset during TRANSFER bit 4.
    issue(8'h96, 8'h69, 1'b0, 1'b0, 1, 1, 1'b0);
    repeat (19) tick();
    rst = 1'b0;
    #1;
    check("arst_mosi", 32'(mosi), 32'd0);
    check("arst_sck", 32'(sck), 32'd0);
    check("arst_cs_n", 32'(cs_n), 32'hF);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_new_data", 32'(new_data), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    issue(8'h3E, 8'hB1, 1'b1, 1'b0, 1, 0, 1'b0);

    // Randomized transfers, including bursts through HOLD.
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, NCS - 1)),
            ($urandom_range(0, 2) == 0));
    end
    wait_idle();
    release_cs = 1'b1;
    tick();
    release_cs = 1'b0;
    check("final_release_cs_n", 32'(cs_n), 32'hF);

    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) fail("drain_timeout");
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master, successor to the fixed 8-bit mode-0-style master.
- Adds a configurable word width, all four CPOL/CPHA modes and a runtime clock divider.
- Drives NUM_CS active-low chip selects, with optional CS hold between words for bursts.
- Connects host-side logic (register interface, neuron-state streaming) to external SPI peripherals.

Parameters:
DATA_WIDTH, 8, bits per word (>=2); MSB first
NUM_CS, 4, number of chip-select outputs (>=1)
DIV_WIDTH, 8, width of clk_div input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  request a word transfer; accepted only when busy=0
data_in  in  DATA_WIDTH  word to transmit, latched on accept
cpol  in  1  SCK idle level, latched on accept
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accept
clk_div  in  DIV_WIDTH  half-period H = clk_div+1 clk cycles, latched on accept
cs_sel  in  $clog2(NUM_CS) (min 1)  chip-select index, latched on accept
hold_cs  in  1  keep CS asserted after this word, latched on accept
release  in  1  deassert a held CS (HOLD state only)
miso  in  1  serial data in
mosi  out  1  serial data out
sck  out  1  serial clock
cs_n  out  NUM_CS  active-low chip selects
data_out  out  DATA_WIDTH  last received word
busy  out  1  transfer in progress
new_data  out  1  one-cycle pulse, data_out valid

Behaviour:
- Reset (rst=0, async, dominates everything):
  - mosi=0, sck=0, cs_n=all 1, data_out=0, busy=0, new_data=0.
  - Latched cpol=0; state=IDLE.
  - Applies immediately mid-transfer; no partial data_out update.
- States: IDLE, SETUP, TRANSFER, FINISH, HOLD. busy=1 in SETUP, TRANSFER and FINISH only.
- IDLE:
  - cs_n all 1; sck=latched cpol.
  - start=1 latches all config and data_in, then enters SETUP next cycle.
- SETUP (H cycles):
  - cs_n[cs_sel]=0.
  - If cpha=0, mosi=data MSB from the first SETUP cycle.
- TRANSFER (2*DATA_WIDTH half-periods of H cycles each):
  - sck toggles on the first cycle of each half-period, starting at TRANSFER entry.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - cpha=0: miso shifted in at leading edges; mosi advances at trailing edges except the last, so mosi holds the LSB.
  - cpha=1: mosi driven at leading edges (MSB at the first); miso shifted in at trailing edges.
  - miso is sampled on the same clk edge that drives sck to the sampling level.
- FINISH (H cycles): sck at idle level; CS still asserted.
- On FINISH exit:
  - data_out updated, new_data=1 for exactly one cycle, busy=0 in that same cycle.
  - Next state is HOLD if hold_cs was latched, else IDLE with CS deasserted that cycle.
- Total busy duration = H*(2*DATA_WIDTH+2) cycles.
- HOLD:
  - cs_n keeps the held line low; sck idle.
  - start re-latches config and enters SETUP; the CS line switches immediately if cs_sel differs.
  - release=1 (no start) goes to IDLE and deasserts CS next cycle.
  - start and release together: start wins.
- start while busy=1 is ignored; no queueing.
- cs_sel >= NUM_CS: the transfer runs normally with no cs_n asserted.
- Config inputs are don't-care except on the accepting cycle.

Test Plan:
1. Mode 0, W=8, clk_div=1, mosi looped to miso, data_in=0xA5 -> 8 rising sck edges; data_out=0xA5; busy high exactly 36 cycles; new_data one pulse; cs_n[0] low only while busy.
2. Mode 3 (cpol=1, cpha=1), clk_div=0, miso driven with 0x3C MSB-first, changing on falling edges -> sck idles high; data_out=0x3C; mosi bits change on falling edges.
3. Burst: hold_cs=1 with 0x11, then start from HOLD with hold_cs=0 and 0x22 -> cs_n[2] stays low across both words; two new_data pulses; cs_n[2] high after the second word.
4. cs_sel=3 in HOLD, then release=1 -> cs_n returns to 4'b1111 next cycle; busy stays 0; no new_data.
5. Assert start while busy mid-word -> ignored; data_out unchanged until the original word completes.
6. Drop rst during TRANSFER bit 4 -> outputs take reset values immediately; a new start after release transfers correctly.
